// File: rtl/sound_pkg.sv
// Shared sound definitions used by the request arbiter and the music player.
//   TUNE_ID            : tune selector carried from arbiter to player; the
//                        encoding doubles as the priority order
//                        (larger value = higher priority).
//   NOTE_Pulse_Per_Sec : clk ticks per second, the player's note-timing base.
//   DEFAULT_*_CYCLES   : default play length of each tune in clk cycles.
//   highest_pending()  : picks the highest-priority tune among pending flags.
package sound_pkg;

    typedef enum logic [1:0] {
        TUNE_None = 2'd0,
        TUNE_BTN  = 2'd1,
        TUNE_WIN  = 2'd2,
        TUNE_OVER = 2'd3
    } TUNE_ID;

    localparam int unsigned NOTE_Pulse_Per_Sec = 50_000_000;

    localparam int unsigned DEFAULT_BTN_CYCLES  = 50_000;
    localparam int unsigned DEFAULT_WIN_CYCLES  = 1_750_000;
    localparam int unsigned DEFAULT_OVER_CYCLES = 1_750_000;

    function automatic TUNE_ID highest_pending(input logic over, input logic win,
                                               input logic btn);
        TUNE_ID t;
        t = TUNE_None;
        if (over) begin
            t = TUNE_OVER;
        end else if (win) begin
            t = TUNE_WIN;
        end else if (btn) begin
            t = TUNE_BTN;
        end
        return t;
    endfunction

endpackage

// File: rtl/sound_request_arbiter.sv
// Sound request arbiter: turns game events into start strobes for the music
// player, ranking OVER > WIN > BTN, with an inline play-length timer.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   evt_btn  : button-click request (only accepted while nothing is playing)
//   evt_win  : victory request
//   evt_over : game-over request
//   mute     : level; silences output and discards requests
//   new_tune : one-cycle start strobe to the player
//   tune_id  : tune to start, valid with new_tune, held between strobes
//   busy     : high while an issued tune is still timed as playing
module sound_request_arbiter
    import sound_pkg::*;
#(
    parameter int unsigned BTN_CYCLES  = DEFAULT_BTN_CYCLES,
    parameter int unsigned WIN_CYCLES  = DEFAULT_WIN_CYCLES,
    parameter int unsigned OVER_CYCLES = DEFAULT_OVER_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_btn,
    input  logic       evt_win,
    input  logic       evt_over,
    input  logic       mute,
    output logic       new_tune,
    output logic [1:0] tune_id,
    output logic       busy
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state_q, state_d;
    logic        pend_btn_q, pend_btn_d;
    logic        pend_win_q, pend_win_d;
    logic        pend_over_q, pend_over_d;
    logic [31:0] timer_q, timer_d;
    logic        new_tune_q, new_tune_d;
    TUNE_ID      tune_q, tune_d;
    logic        busy_q, busy_d;

    TUNE_ID      best;
    logic        issue;
    logic [31:0] len_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_btn_q  <= 1'b0;
            pend_win_q  <= 1'b0;
            pend_over_q <= 1'b0;
            timer_q     <= '0;
            new_tune_q  <= 1'b0;
            tune_q      <= TUNE_None;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_btn_q  <= pend_btn_d;
            pend_win_q  <= pend_win_d;
            pend_over_q <= pend_over_d;
            timer_q     <= timer_d;
            new_tune_q  <= new_tune_d;
            tune_q      <= tune_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        best = highest_pending(pend_over_q, pend_win_q, pend_btn_q);

        unique case (best)
            TUNE_OVER: len_m1 = OVER_CYCLES - 32'd1;
            TUNE_WIN:  len_m1 = WIN_CYCLES - 32'd1;
            TUNE_BTN:  len_m1 = BTN_CYCLES - 32'd1;
            default:   len_m1 = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_btn_d  = pend_btn_q;
        pend_win_d  = pend_win_q;
        pend_over_d = pend_over_q;
        timer_d     = timer_q;
        new_tune_d  = 1'b0;
        tune_d      = tune_q;
        busy_d      = busy_q;
        issue       = 1'b0;

        if (mute) begin
            pend_btn_d  = 1'b0;
            pend_win_d  = 1'b0;
            pend_over_d = 1'b0;
            // Mute can only be seen in PLAY once: it drops us to IDLE and
            // blocks further issuing, so this is the single silence strobe.
            if (state_q == PLAY) begin
                state_d    = IDLE;
                new_tune_d = 1'b1;
                tune_d     = TUNE_None;
                busy_d     = 1'b0;
                timer_d    = '0;
            end
        end else begin
            if (evt_over) pend_over_d = 1'b1;
            if (evt_win)  pend_win_d  = 1'b1;
            // Every tune outranks or equals BTN, so BTN is only accepted idle.
            if (state_q == IDLE && evt_btn) pend_btn_d = 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (best != TUNE_None) issue = 1'b1;
                end
                PLAY: begin
                    if (timer_q == '0) begin
                        if (best != TUNE_None) begin
                            issue = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (best > tune_q) begin
                        issue = 1'b1;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (issue) begin
                state_d    = PLAY;
                new_tune_d = 1'b1;
                tune_d     = best;
                busy_d     = 1'b1;
                timer_d    = len_m1;
                // A button click left over from IDLE must not wait behind
                // the tune just started; WIN/OVER arriving on the issue
                // edge stay pending so they replay back-to-back.
                pend_btn_d = 1'b0;
                if (best == TUNE_OVER && !evt_over) pend_over_d = 1'b0;
                if (best == TUNE_WIN && !evt_win)   pend_win_d  = 1'b0;
            end
        end
    end

    assign new_tune = new_tune_q;
    assign tune_id  = tune_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Scoreboard bench for sound_request_arbiter (BTN=10, WIN=40, OVER=40).
// Stimulus pushes expected strobes, busy falling edges and output snapshots
// (keyed by edge number); a monitor at each negedge pops and compares.
module tb_sound_request_arbiter;

    localparam int BTN  = 10;
    localparam int WIN  = 40;
    localparam int OVER = 40;
    localparam int ID_NONE = 0, ID_BTN = 1, ID_WIN = 2, ID_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       evt_btn, evt_win, evt_over, mute;
    logic       new_tune;
    logic [1:0] tune_id;
    logic       busy;

    sound_request_arbiter #(
        .BTN_CYCLES (BTN),
        .WIN_CYCLES (WIN),
        .OVER_CYCLES(OVER)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .evt_btn (evt_btn),
        .evt_win (evt_win),
        .evt_over(evt_over),
        .mute    (mute),
        .new_tune(new_tune),
        .tune_id (tune_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after the n-th rising edge, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int id;
    } strobe_t;

    typedef struct {
        int cyc;
        int nt;
        int id;
        int bz;
    } snap_t;

    strobe_t strobe_q[$];
    int      fall_q[$];
    snap_t   snap_q[$];
    bit      done = 1'b0;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic exp_strobe(input int c, input int id);
        strobe_t s;
        s.cyc = c;
        s.id  = id;
        strobe_q.push_back(s);
    endtask

    task automatic exp_snap(input int c, input int nt, input int id, input int bz);
        snap_t s;
        s.cyc = c;
        s.nt  = nt;
        s.id  = id;
        s.bz  = bz;
        snap_q.push_back(s);
    endtask

    // Land on the negedge following edge n.
    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Hold events {over,win,btn}=m high so they are sampled at edges e1..e2.
    task automatic pulse(input logic [2:0] m, input int e1, input int e2);
        at_neg(e1 - 1);
        evt_over = m[2];
        evt_win  = m[1];
        evt_btn  = m[0];
        at_neg(e2);
        evt_over = 1'b0;
        evt_win  = 1'b0;
        evt_btn  = 1'b0;
    endtask

    // Monitor: all comparisons happen here.
    initial begin : monitor
        bit      busy_prev;
        strobe_t s;
        snap_t   sn;
        int      f;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                sn = snap_q.pop_front();
                check("snap_edge", cyc, sn.cyc);
                check("snap_new_tune", int'(new_tune), sn.nt);
                check("snap_tune_id", int'(tune_id), sn.id);
                check("snap_busy", int'(busy), sn.bz);
            end
            if (new_tune === 1'b1) begin
                if (strobe_q.size() == 0) begin
                    check("unexpected_strobe_id", int'(tune_id), -1);
                end else begin
                    s = strobe_q.pop_front();
                    check("strobe_edge", cyc, s.cyc);
                    check("strobe_tune_id", int'(tune_id), s.id);
                end
            end
            if (busy_prev && busy !== 1'b1) begin
                if (fall_q.size() == 0) begin
                    check("unexpected_busy_fall_edge", cyc, -1);
                end else begin
                    f = fall_q.pop_front();
                    check("busy_fall_edge", cyc, f);
                end
            end
            busy_prev = (busy === 1'b1);
            if (done || cyc > 3000) begin
                check("timeout", int'(cyc > 3000), 0);
                check("strobes_missing", strobe_q.size(), 0);
                check("busy_falls_missing", fall_q.size(), 0);
                check("snaps_missing", snap_q.size(), 0);
                $display("%0d/%0d checks passed", passed, checks);
                $finish;
            end
        end
    end

    initial begin : stimulus
        int b;
        rst_n = 1'b0;
        evt_btn = 1'b0;
        evt_win = 1'b0;
        evt_over = 1'b0;
        mute = 1'b0;
        exp_snap(2, 0, ID_NONE, 0);
        at_neg(3);
        rst_n = 1'b1;

        // Button click from IDLE: strobe one edge after sampling, busy BTN cycles.
        b = cyc;
        exp_strobe(b + 6, ID_BTN);
        exp_snap(b + 10, 0, ID_BTN, 1);
        fall_q.push_back(b + 6 + BTN);
        exp_snap(b + 20, 0, ID_BTN, 0);
        pulse(3'b001, b + 5, b + 5);
        at_neg(b + 25);

        // WIN then BTN while playing: BTN dropped.
        b = cyc;
        exp_strobe(b + 6, ID_WIN);
        fall_q.push_back(b + 6 + WIN);
        pulse(3'b010, b + 5, b + 5);
        pulse(3'b001, b + 10, b + 10);
        at_neg(b + 60);

        // WIN then OVER preempts with timer reload.
        b = cyc;
        exp_strobe(b + 6, ID_WIN);
        exp_strobe(b + 16, ID_OVER);
        fall_q.push_back(b + 16 + OVER);
        pulse(3'b010, b + 5, b + 5);
        pulse(3'b100, b + 15, b + 15);
        at_neg(b + 70);

        // OVER and WIN together: OVER first, WIN back-to-back.
        b = cyc;
        exp_strobe(b + 6, ID_OVER);
        exp_strobe(b + 6 + OVER, ID_WIN);
        exp_snap(b + 6 + OVER - 1, 0, ID_OVER, 1);
        fall_q.push_back(b + 6 + OVER + WIN);
        pulse(3'b110, b + 5, b + 5);
        at_neg(b + 100);

        // Mute 8 cycles into WIN: silence strobe, busy drops, events ignored.
        b = cyc;
        exp_strobe(b + 6, ID_WIN);
        exp_strobe(b + 14, ID_NONE);
        fall_q.push_back(b + 14);
        exp_snap(b + 30, 0, ID_NONE, 0);
        pulse(3'b010, b + 5, b + 5);
        at_neg(b + 13);
        mute = 1'b1;
        pulse(3'b100, b + 18, b + 18);
        at_neg(b + 21);
        mute = 1'b0;
        at_neg(b + 40);

        // WIN held across its own issue edge stays pending and replays.
        b = cyc;
        exp_strobe(b + 6, ID_WIN);
        exp_strobe(b + 6 + WIN, ID_WIN);
        fall_q.push_back(b + 6 + 2 * WIN);
        pulse(3'b010, b + 5, b + 6);
        at_neg(b + 95);

        // BTN held across its issue edge gives a single click.
        b = cyc;
        exp_strobe(b + 6, ID_BTN);
        fall_q.push_back(b + 6 + BTN);
        pulse(3'b001, b + 5, b + 7);
        at_neg(b + 25);

        // Reset mid-PLAY: outputs clear before the next clock edge.
        b = cyc;
        exp_strobe(b + 6, ID_WIN);
        exp_snap(b + 10, 0, ID_NONE, 0);
        exp_snap(b + 11, 0, ID_NONE, 0);
        fall_q.push_back(b + 10);
        exp_strobe(b + 16, ID_BTN);
        fall_q.push_back(b + 16 + BTN);
        pulse(3'b010, b + 5, b + 5);
        at_neg(b + 9);
        @(posedge clk);
        #1 rst_n = 1'b0;
        at_neg(b + 12);
        rst_n = 1'b1;
        pulse(3'b001, b + 15, b + 15);
        at_neg(b + 35);

        done = 1'b1;
    end

endmodule
